serial_tx_en: RTL and testbench
===============================

# serial_tx_en

Enable-paced serial transmitter that turns a parallel word into a framed serial bit stream. The frame is one start bit (0), DATA_W data bits LSB first, and one stop bit (1). The bit rate is set by an external enable tick `en`, the same clock-enable style used by the enable flip-flops in PARTE1. The block sits at the sending end of the serial link and drives the line that the receiving deserializer samples.

## Interface
- DATA_W, 8, payload width in bits (≥2)
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  bit tick; the current bit advances only on a clk edge where en=1
- load  input  1  request to send `d`; accepted only when ready=1
- d  input  DATA_W  parallel word, sampled on the accepting edge
- ready  output  1  1 in IDLE, 0 otherwise
- busy  output  1  1 from the edge after acceptance until the frame ends
- q  output  1  serial line; idles high
- done  output  1  one-cycle pulse on frame completion

## Operation
- States: IDLE, START, DATA, STOP.
- Reset (async, rst_n=0): state=IDLE, q=1, ready=1, busy=0, done=0, shift register=0, bit counter=0.
- IDLE: q=1.
  - On an edge with load=1, latch d into the shift register, clear the bit counter, go to START, and drive q=0.
  - en is ignored in IDLE, including when load=1 on the same edge.
- START: hold q=0 until an edge with en=1.
  - On that edge, go to DATA with q=shift[0].
- DATA: on each en=1 edge, shift right.
  - After DATA_W bits have been presented (counter reaches DATA_W-1 and en=1), go to STOP with q=1.
  - Otherwise present the next bit: q=shift[1] before the shift, and counter+1.
- STOP: hold q=1 until an edge with en=1.
  - On that edge, go to IDLE, assert done for exactly that following cycle, and set busy=0 and ready=1.
- load while busy: ignored, with no effect on the frame in flight; d may change freely.
- Counter width: $clog2(DATA_W) bits; it never wraps within a frame.
- A back-to-back load in the cycle when done=1 is accepted, since ready=1.
- Reset mid-frame: the frame is abandoned immediately, q returns to 1, and no done is produced.

## Timing
- Acceptance edge k: from k+ on, q=0, busy=1, ready=0.
- Each bit occupies the interval between consecutive en=1 edges (the acceptance edge does not count).
- The start bit can be as short as 1 cycle if en=1 on edge k+1.
- Frame length: exactly DATA_W+2 en=1 edges after acceptance.
- done is high for 1 cycle, starting at the edge of the final en tick. done=1 coincides with ready=1, busy=0, q=1.
- All outputs are registered; there are no combinational paths from inputs to q, busy, or done.
- ready is decoded from state only (state==IDLE) and does not depend on load.

## Structure
- Package serial_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1
  - the same package is shared with the receiver
- Sub-module: piso_shift (DATA_W parallel-load, enable-gated right shift, exposes bit0).
- The FSM and bit counter live in serial_tx_en.

## Test plan
- Basic frame: DATA_W=8, en high every 2nd cycle, d=8'hA5 with load for 1 cycle.
  - q over successive bit periods = 0, 1,0,1,0,0,1,0,1, 1.
  - done pulses once after the 10th en tick; ready=1 afterward.
- en held high: d=8'h01. Each bit lasts 1 cycle: q=0,1,0,0,0,0,0,0,0,1.
  - Total busy = 10 cycles.
- load during busy: start d=8'hF0, then pulse load with d=8'h0F mid-DATA.
  - The transmitted payload stays 8'hF0 (q data bits 0,0,0,0,1,1,1,1).
  - Exactly one done pulse.
- Back-to-back frames: load=1 in the done cycle with d=8'h3C.
  - The second start bit begins the next cycle; no idle-high gap beyond the done cycle.
  - Second payload = 0,0,1,1,1,1,0,0.
- Reset mid-frame: assert rst_n=0 asynchronously during DATA bit 4 of 8'hAA.
  - q=1, ready=1, busy=0 within the same cycle, with no done.
  - After release, a new load of 8'h55 transmits correctly.
- Load with en coincident in IDLE: load=1 and en=1 on the same edge.
  - The start bit is still held until the next en=1 edge, i.e. it is not skipped.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver).
//   state_t     : frame FSM states
//   *_LEVEL     : line levels for idle, start and stop bits
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, right shift toward bit0.
//   clk, rst_n : clock, async active-low reset
//   load       : parallel load of d (has priority over shift)
//   shift      : enable-gated right shift, zero fill at the MSB
//   d          : parallel word
//   bit0       : current LSB of the register
module piso_shift #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              bit0
);

  logic [DATA_W-1:0] sr;

  // Shift storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= {1'b0, sr[DATA_W-1:1]};
    end
  end

  assign bit0 = sr[0];

endmodule

// File: rtl/serial_tx_en.sv
// Enable-paced framed serial transmitter: start(0), DATA_W bits LSB first, stop(1).
//   clk, rst_n : clock, async active-low reset
//   en         : bit tick, the line advances only on edges with en=1
//   load, d    : send request and payload, accepted while ready=1
//   ready      : idle and able to accept a word
//   busy       : frame in flight
//   q          : serial line, idles high
//   done       : one-cycle pulse when the stop bit ends
module serial_tx_en
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic              ready,
  output logic              busy,
  output logic              q,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               q_n, busy_n, done_n, ready_n;
  logic               sr_load, sr_shift, sr_bit0;

  // The register shifts on the start->data tick as well, so bit0 always
  // holds the next bit to present and only bit0 needs to be exposed.
  piso_shift #(.DATA_W(DATA_W)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (d),
    .bit0  (sr_bit0)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= IDLE_LEVEL;
      busy  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      busy  <= busy_n;
      done  <= done_n;
      ready <= ready_n;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    q_n      = q;
    busy_n   = busy;
    done_n   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    case (state)
      IDLE: begin
        q_n    = IDLE_LEVEL;
        busy_n = 1'b0;
        if (load) begin
          sr_load = 1'b1;
          cnt_n   = '0;
          state_n = START;
          q_n     = START_LEVEL;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (en) begin
          sr_shift = 1'b1;
          state_n  = DATA;
          q_n      = sr_bit0;
        end
      end
      DATA: begin
        if (en) begin
          sr_shift = 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state_n = STOP;
            q_n     = STOP_LEVEL;
          end else begin
            q_n   = sr_bit0;
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (en) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          q_n     = IDLE_LEVEL;
        end
      end
      default: begin
        state_n = IDLE;
        q_n     = IDLE_LEVEL;
        busy_n  = 1'b0;
      end
    endcase

    ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_serial_tx_en.sv
// Directed self-checking bench for serial_tx_en (DATA_W=8).
module tb_serial_tx_en;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] d;
  logic       ready;
  logic       busy;
  logic       q;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  serial_tx_en #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .d     (d),
    .ready (ready),
    .busy  (busy),
    .q     (q),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses by the value held before each rising edge
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge
  task automatic step(input logic en_v, input logic load_v, input logic [7:0] d_v);
    en   = en_v;
    load = load_v;
    d    = d_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept a word and confirm the start bit appears right after the accepting edge
  task automatic load_word(input string name, input logic [7:0] w, input logic en_v);
    step(en_v, 1'b1, w);
    check_eq({name, " start q"}, 32'(q), 32'd0);
    check_eq({name, " start busy"}, 32'(busy), 32'd1);
    check_eq({name, " start ready"}, 32'(ready), 32'd0);
  endtask

  // Play out one frame: each bit lasts gap cycles, en on the last cycle of each bit.
  // inject pulses load with 8'h0F during data bit 3 to prove it is ignored.
  task automatic play_frame(input string name, input logic [7:0] w, input int gap, input bit inject);
    logic exp_bit;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_bit = 1'b0;
      else if (i == 9) exp_bit = 1'b1;
      else             exp_bit = w[i-1];
      for (int c = 0; c < gap; c++) begin
        check_eq($sformatf("%s q bit%0d cyc%0d", name, i, c), 32'(q), 32'(exp_bit));
        check_eq($sformatf("%s busy bit%0d cyc%0d", name, i, c), 32'(busy), 32'd1);
        check_eq($sformatf("%s ready bit%0d cyc%0d", name, i, c), 32'(ready), 32'd0);
        check_eq($sformatf("%s done bit%0d cyc%0d", name, i, c), 32'(done), 32'd0);
        if (inject && i == 4 && c == 0 && gap > 1)
          step(1'b0, 1'b1, 8'h0F);
        else
          step(c == gap - 1, 1'b0, inject ? 8'h0F : w);
      end
    end
    check_eq({name, " done pulse"}, 32'(done), 32'd1);
    check_eq({name, " done ready"}, 32'(ready), 32'd1);
    check_eq({name, " done busy"}, 32'(busy), 32'd0);
    check_eq({name, " done q"}, 32'(q), 32'd1);
  endtask

  // Idle one cycle after a frame and confirm done was a single-cycle pulse
  task automatic idle_after(input string name, input int cnt_before);
    step(1'b0, 1'b0, 8'h00);
    check_eq({name, " done low"}, 32'(done), 32'd0);
    check_eq({name, " idle q"}, 32'(q), 32'd1);
    check_eq({name, " idle ready"}, 32'(ready), 32'd1);
    check_eq({name, " done count"}, 32'(done_cnt - cnt_before), 32'd1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    d     = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset q", 32'(q), 32'd1);
    check_eq("reset ready", 32'(ready), 32'd1);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    check_eq("idle en q", 32'(q), 32'd1);
    check_eq("idle en ready", 32'(ready), 32'd1);

    // Basic frame, en every 2nd cycle
    dc = done_cnt;
    load_word("a5", 8'hA5, 1'b0);
    play_frame("a5", 8'hA5, 2, 1'b0);
    idle_after("a5", dc);

    // en held high: one cycle per bit, 10 busy cycles
    dc = done_cnt;
    load_word("01", 8'h01, 1'b0);
    play_frame("01", 8'h01, 1, 1'b0);
    idle_after("01", dc);

    // load while busy is ignored
    dc = done_cnt;
    load_word("f0", 8'hF0, 1'b0);
    play_frame("f0", 8'hF0, 2, 1'b1);
    idle_after("f0", dc);

    // Back-to-back: second load in the done cycle
    dc = done_cnt;
    load_word("b2b1", 8'hC3, 1'b0);
    play_frame("b2b1", 8'hC3, 2, 1'b0);
    load_word("b2b2", 8'h3C, 1'b0);
    play_frame("b2b2", 8'h3C, 2, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check_eq("b2b done count", 32'(done_cnt - dc), 32'd2);

    // Reset during data bit 4 of 8'hAA
    dc = done_cnt;
    load_word("aa", 8'hAA, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 8'hAA);
      step(1'b1, 1'b0, 8'hAA);
    end
    check_eq("aa bit4 q", 32'(q), 32'd0);
    check_eq("aa bit4 busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst q", 32'(q), 32'd1);
    check_eq("rst ready", 32'(ready), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    check_eq("rst no done", 32'(done_cnt - dc), 32'd0);
    check_eq("rst idle q", 32'(q), 32'd1);
    dc = done_cnt;
    load_word("55", 8'h55, 1'b0);
    play_frame("55", 8'h55, 2, 1'b0);
    idle_after("55", dc);

    // load and en on the same idle edge: start bit must still last until the next tick
    dc = done_cnt;
    load_word("81", 8'h81, 1'b1);
    play_frame("81", 8'h81, 2, 1'b0);
    idle_after("81", dc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
